// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 PRGA / message decryptor.
//   - rc4_state_e : FSM state encoding (one state per memory access step)
//   - CHAR_LO, CHAR_HI, CHAR_SPACE : bounds of the accepted plaintext set
//   - MSG_LEN_DEFAULT : default encrypted-message length in bytes
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_READ_I  = 4'd1,
    ST_WAIT_I  = 4'd2,
    ST_LATCH_I = 4'd3,
    ST_WAIT_J  = 4'd4,
    ST_LATCH_J = 4'd5,
    ST_WRITE_J = 4'd6,
    ST_WRITE_I = 4'd7,
    ST_READ_F  = 4'd8,
    ST_WAIT_F  = 4'd9,
    ST_LATCH_F = 4'd10,
    ST_WRITE_D = 4'd11,
    ST_NEXT    = 4'd12,
    ST_DONE    = 4'd13
  } rc4_state_e;

endpackage

// File: rtl/rc4_decryptor_char_check.sv
// rc4_char_check: combinational plaintext filter, also reused by the key
// selection logic.
//   i_char  : candidate plaintext byte
//   o_valid : 1 when i_char is a lowercase letter (a..z) or a space
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_valid
);

  assign o_valid = ((i_char >= CHAR_LO) && (i_char <= CHAR_HI)) ||
                   (i_char == CHAR_SPACE);

endmodule

// File: rtl/rc4_decryptor.sv
// rc4_decryptor: RC4 keystream generator (PRGA) and message decryptor.
// Walks the already-shuffled S array in the shared S RAM, XORs each keystream
// byte with the encrypted ROM and writes the plaintext to the decrypted RAM.
// A plaintext byte outside {a..z, space} raises o_fail and ends the run early.
//   clk, reset_n                : clock, asynchronous active-low reset
//   i_start                     : level request, only looked at in IDLE
//   i_s_q / o_s_address / o_s_data / o_s_wren : S RAM port
//   i_enc_q / o_enc_address     : encrypted message ROM port
//   o_dec_address / o_dec_data / o_dec_wren   : decrypted message RAM port
//   o_finish                    : one-cycle pulse at the end of a run
//   o_fail                      : invalid plaintext seen, held until next start
// All memories have a registered address: data for an address presented in
// cycle n is usable in cycle n+1. Every output is a register, so the comb
// block computes the values the outputs must show in the *next* state.
module rc4_decryptor
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  // a one-byte message still needs a one-bit address port
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic [7:0]    i_s_q,
  output logic [7:0]    o_s_address,
  output logic [7:0]    o_s_data,
  output logic          o_s_wren,
  input  logic [7:0]    i_enc_q,
  output logic [AW-1:0] o_enc_address,
  output logic [AW-1:0] o_dec_address,
  output logic [7:0]    o_dec_data,
  output logic          o_dec_wren,
  output logic          o_finish,
  output logic          o_fail
);

  localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);
  localparam logic [AW-1:0] K_ZERO = AW'(0);
  localparam logic [AW-1:0] K_ONE  = AW'(1);

  rc4_state_e    r_state, w_state;
  logic [7:0]    r_i, w_i;
  logic [7:0]    r_j, w_j;
  logic [AW-1:0] r_k, w_k;
  logic [7:0]    r_si, w_si;
  logic [7:0]    r_sj, w_sj;
  logic [7:0]    r_f, w_f;

  logic [7:0]    r_s_address, w_s_address;
  logic [7:0]    r_s_data, w_s_data;
  logic          r_s_wren, w_s_wren;
  logic [AW-1:0] r_enc_address, w_enc_address;
  logic [AW-1:0] r_dec_address, w_dec_address;
  logic [7:0]    r_dec_data, w_dec_data;
  logic          r_dec_wren, w_dec_wren;
  logic          r_finish, w_finish;
  logic          r_fail, w_fail;

  logic [7:0]    w_plain;
  logic          w_plain_valid;

  // enc ROM address stays at k from READ_F onwards, so enc_q is still valid
  // while f is latched and can be combined on the way into WRITE_D.
  assign w_plain = r_f ^ i_enc_q;

  rc4_char_check u_char_check (
    .i_char  (w_plain),
    .o_valid (w_plain_valid)
  );

  // Next-state and next-output logic; values are what the next state shows.
  always_comb begin
    w_state       = r_state;
    w_i           = r_i;
    w_j           = r_j;
    w_k           = r_k;
    w_si          = r_si;
    w_sj          = r_sj;
    w_f           = r_f;
    w_s_address   = r_s_address;
    w_s_data      = r_s_data;
    w_s_wren      = 1'b0;
    w_enc_address = r_enc_address;
    w_dec_address = r_dec_address;
    w_dec_data    = r_dec_data;
    w_dec_wren    = 1'b0;
    w_finish      = 1'b0;
    w_fail        = r_fail;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state     = ST_READ_I;
          w_i         = 8'd1;
          w_j         = 8'd0;
          w_k         = K_ZERO;
          w_fail      = 1'b0;
          w_s_address = 8'd1;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_READ_I: w_state = ST_WAIT_I;
      ST_WAIT_I: begin
        // s[i] is on i_s_q now; LATCH_I already presents the new j
        w_state     = ST_LATCH_I;
        w_si        = i_s_q;
        w_j         = r_j + i_s_q;
        w_s_address = r_j + i_s_q;
      end
      ST_LATCH_I: w_state = ST_WAIT_J;
      ST_WAIT_J: begin
        w_state = ST_LATCH_J;
        w_sj    = i_s_q;
      end
      ST_LATCH_J: begin
        w_state     = ST_WRITE_J;
        w_s_address = r_j;
        w_s_data    = r_si;
        w_s_wren    = 1'b1;
      end
      ST_WRITE_J: begin
        w_state     = ST_WRITE_I;
        w_s_address = r_i;
        w_s_data    = r_sj;
        w_s_wren    = 1'b1;
      end
      ST_WRITE_I: begin
        w_state       = ST_READ_F;
        w_s_address   = r_si + r_sj;
        w_enc_address = r_k;
      end
      ST_READ_F: w_state = ST_WAIT_F;
      ST_WAIT_F: begin
        w_state = ST_LATCH_F;
        w_f     = i_s_q;
      end
      ST_LATCH_F: begin
        // the byte is written even when it fails the character check
        w_state       = ST_WRITE_D;
        w_dec_address = r_k;
        w_dec_data    = w_plain;
        w_dec_wren    = 1'b1;
        if (!w_plain_valid) begin
          w_fail = 1'b1;
        end else begin
          w_fail = r_fail;
        end
      end
      ST_WRITE_D: w_state = ST_NEXT;
      ST_NEXT: begin
        if (r_fail || (r_k == K_LAST)) begin
          w_state  = ST_DONE;
          w_finish = 1'b1;
        end else begin
          w_state     = ST_READ_I;
          w_k         = r_k + K_ONE;
          w_i         = r_i + 8'd1;
          w_s_address = r_i + 8'd1;
        end
      end
      ST_DONE: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_i           <= 8'd0;
      r_j           <= 8'd0;
      r_k           <= K_ZERO;
      r_si          <= 8'd0;
      r_sj          <= 8'd0;
      r_f           <= 8'd0;
      r_s_address   <= 8'd0;
      r_s_data      <= 8'd0;
      r_s_wren      <= 1'b0;
      r_enc_address <= K_ZERO;
      r_dec_address <= K_ZERO;
      r_dec_data    <= 8'd0;
      r_dec_wren    <= 1'b0;
      r_finish      <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_i           <= w_i;
      r_j           <= w_j;
      r_k           <= w_k;
      r_si          <= w_si;
      r_sj          <= w_sj;
      r_f           <= w_f;
      r_s_address   <= w_s_address;
      r_s_data      <= w_s_data;
      r_s_wren      <= w_s_wren;
      r_enc_address <= w_enc_address;
      r_dec_address <= w_dec_address;
      r_dec_data    <= w_dec_data;
      r_dec_wren    <= w_dec_wren;
      r_finish      <= w_finish;
      r_fail        <= w_fail;
    end
  end

  assign o_s_address   = r_s_address;
  assign o_s_data      = r_s_data;
  assign o_s_wren      = r_s_wren;
  assign o_enc_address = r_enc_address;
  assign o_dec_address = r_dec_address;
  assign o_dec_data    = r_dec_data;
  assign o_dec_wren    = r_dec_wren;
  assign o_finish      = r_finish;
  assign o_fail        = r_fail;

endmodule

// File: tb/tb_rc4_decryptor.sv
// Self-checking bench for rc4_decryptor: a 32-byte instance driven from a
// vector table plus hand sequences, and a 1-byte instance. Expected plaintext,
// keystream and final S contents come from a plain RC4 model (KSA + PRGA).
module tb_rc4_decryptor;

  localparam int ML = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- 32-byte instance and its memories ----------------
  logic       i_start;
  logic [7:0] s_q, o_s_address, o_s_data, enc_q, o_dec_data;
  logic       o_s_wren, o_dec_wren, o_finish, o_fail;
  logic [4:0] o_enc_address, o_dec_address;

  rc4_decryptor #(.MSG_LEN(ML)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start),
    .i_s_q(s_q), .o_s_address(o_s_address), .o_s_data(o_s_data), .o_s_wren(o_s_wren),
    .i_enc_q(enc_q), .o_enc_address(o_enc_address),
    .o_dec_address(o_dec_address), .o_dec_data(o_dec_data), .o_dec_wren(o_dec_wren),
    .o_finish(o_finish), .o_fail(o_fail)
  );

  logic [7:0] s_mem [256];
  logic [7:0] s_img [256];
  logic [7:0] s_addr_r;
  logic       s_load, dec_clr;
  logic [7:0] enc_mem [ML];
  logic [4:0] enc_addr_r;
  logic [7:0] dec_mem [ML];

  always @(posedge clk) begin
    if (s_load) begin
      for (int n = 0; n < 256; n++) s_mem[n] <= s_img[n];
    end else if (o_s_wren) begin
      s_mem[o_s_address] <= o_s_data;
    end
    s_addr_r   <= o_s_address;
    enc_addr_r <= o_enc_address;
  end
  assign s_q   = s_mem[s_addr_r];
  assign enc_q = enc_mem[enc_addr_r];

  always @(posedge clk) begin
    if (dec_clr) begin
      for (int n = 0; n < ML; n++) dec_mem[n] <= 8'hEE;
    end else if (o_dec_wren) begin
      dec_mem[o_dec_address] <= o_dec_data;
    end
  end

  // ---------------- 1-byte instance ----------------
  logic       b_start, b_s_wren, b_dec_wren, b_finish, b_fail;
  logic [7:0] b_s_q, b_s_address, b_s_data, b_enc_q, b_dec_data;
  logic [0:0] b_enc_address, b_dec_address;
  logic [7:0] s1_mem [256];
  logic [7:0] s1_addr_r;
  logic [7:0] enc1_mem [2];
  logic [0:0] enc1_addr_r;

  rc4_decryptor #(.MSG_LEN(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_start(b_start),
    .i_s_q(b_s_q), .o_s_address(b_s_address), .o_s_data(b_s_data), .o_s_wren(b_s_wren),
    .i_enc_q(b_enc_q), .o_enc_address(b_enc_address),
    .o_dec_address(b_dec_address), .o_dec_data(b_dec_data), .o_dec_wren(b_dec_wren),
    .o_finish(b_finish), .o_fail(b_fail)
  );

  always @(posedge clk) begin
    if (s_load) begin
      for (int n = 0; n < 256; n++) s1_mem[n] <= s_img[n];
    end else if (b_s_wren) begin
      s1_mem[b_s_address] <= b_s_data;
    end
    s1_addr_r   <= b_s_address;
    enc1_addr_r <= b_enc_address;
  end
  assign b_s_q   = s1_mem[s1_addr_r];
  assign b_enc_q = enc1_mem[enc1_addr_r];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_s [256];
  logic [7:0] m_final [256];
  logic [7:0] m_ks [ML];
  logic [7:0] p [ML];
  logic [7:0] mi, mj;
  int         nbytes;

  task automatic model_init(input bit use_key, input logic [23:0] key);
    logic [7:0] j, t, kb;
    for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
    if (use_key) begin
      j = 8'd0;
      for (int n = 0; n < 256; n++) begin
        kb = 8'(key >> (16 - 8 * (n % 3)));
        j = j + m_s[n] + kb;
        t = m_s[n]; m_s[n] = m_s[j]; m_s[j] = t;
      end
    end
    mi = 8'd0;
    mj = 8'd0;
  endtask

  task automatic model_next(output logic [7:0] ks);
    logic [7:0] t, idx;
    mi = mi + 8'd1;
    mj = mj + m_s[mi];
    t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
    idx = m_s[mi] + m_s[mj];
    ks = m_s[idx];
  endtask

  function automatic logic [7:0] rand_valid();
    int r;
    r = $urandom_range(26, 0);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  task automatic apply_enc();
    for (int n = 0; n < ML; n++) enc_mem[n] = p[n] ^ m_ks[n];
  endtask

  task automatic load_mems();
    s_load = 1'b1; dec_clr = 1'b1;
    @(posedge clk); #1;
    s_load = 1'b0; dec_clr = 1'b0;
  endtask

  // Build S, plaintext and ciphertext; bad_pos < 0 means an all-valid message.
  task automatic prepare(input bit use_key, input logic [23:0] key, input int bad_pos, input logic [7:0] bad_val);
    logic [7:0] ks;
    model_init(use_key, key);
    for (int n = 0; n < 256; n++) s_img[n] = m_s[n];
    for (int n = 0; n < ML; n++) p[n] = rand_valid();
    p[1] = 8'h61; p[2] = 8'h7A; p[3] = 8'h20;
    if (bad_pos >= 0) p[bad_pos] = bad_val;
    nbytes = (bad_pos >= 0) ? bad_pos + 1 : ML;
    for (int n = 0; n < ML; n++) begin
      model_next(ks);
      m_ks[n] = ks;
      if (n == nbytes - 1) for (int q = 0; q < 256; q++) m_final[q] = m_s[q];
    end
    apply_enc();
    load_mems();
  endtask

  // ---------------- run driver ----------------
  int res_fin_cyc, res_fin_cnt, res_dwr, res_swr;
  logic res_fail;
  logic [7:0] snap2, snap3, snap5;

  task automatic run_main(input int pulse_at);
    int cyc;
    res_fin_cyc = -1; res_fin_cnt = 0; res_dwr = 0; res_swr = 0; res_fail = 1'bx;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 1;
    while (cyc < 600 && !(res_fin_cyc > 0 && cyc > res_fin_cyc + 3)) begin
      if (o_finish) begin
        res_fin_cnt++;
        if (res_fin_cyc < 0) begin
          res_fin_cyc = cyc;
          res_fail = o_fail;
        end
      end
      if (o_s_wren) res_swr++;
      if (o_dec_wren) begin
        res_dwr++;
        if (res_dwr == 3) begin
          snap2 = s_mem[2]; snap3 = s_mem[3]; snap5 = s_mem[5];
        end
      end
      i_start = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    i_start = 1'b0;
  endtask

  task automatic verify_run(input string tag, input int exp_fin, input logic exp_fail);
    int bad;
    check({tag, "_finish_cycle"}, res_fin_cyc, exp_fin);
    check({tag, "_finish_count"}, res_fin_cnt, 1);
    check({tag, "_fail"}, {31'd0, res_fail}, {31'd0, exp_fail});
    check({tag, "_dec_writes"}, res_dwr, nbytes);
    check({tag, "_s_writes"}, res_swr, 2 * nbytes);
    for (int n = 0; n < nbytes; n++) check($sformatf("%s_dec[%0d]", tag, n), dec_mem[n], p[n]);
    if (nbytes < ML) check({tag, "_dec_untouched"}, dec_mem[nbytes], 8'hEE);
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== m_final[n]) bad++;
    check({tag, "_s_final_mismatches"}, bad, 0);
  endtask

  function automatic logic [23:0] outs_lo();
    return {o_s_address, o_s_data, o_dec_data};
  endfunction
  function automatic logic [13:0] outs_hi();
    return {o_enc_address, o_dec_address, o_s_wren, o_dec_wren, o_finish, o_fail};
  endfunction

  typedef struct {
    bit          use_key;
    logic [23:0] key;
    int          bad_pos;
    logic [7:0]  bad_val;
    logic        exp_fail;
    int          exp_fin;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cyc, b_fin, b_dwr;
    logic [7:0] b_dec_last;
    logic b_fail_at;

    vecs[0] = '{1'b1, 24'h4B1D07, -1, 8'h00, 1'b0, 385};
    vecs[1] = '{1'b1, 24'h000001,  0, 8'h60, 1'b1, 13};
    vecs[2] = '{1'b1, 24'hA5C3FF,  7, 8'h7B, 1'b1, 97};
    vecs[3] = '{1'b0, 24'h000000, 31, 8'h1F, 1'b1, 385};
    vecs[4] = '{1'b1, 24'h123456, 15, 8'h21, 1'b1, 193};
    vecs[5] = '{1'b1, 24'h00FF00, -1, 8'h00, 1'b0, 385};

    reset_n = 1'b0; i_start = 1'b0; b_start = 1'b0;
    s_load = 1'b0; dec_clr = 1'b0;
    enc1_mem[0] = 8'h22; enc1_mem[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_lo", outs_lo(), 24'd0);
    check("reset_outs_hi", outs_hi(), 14'd0);
    check("reset_b_flags", {b_s_wren, b_dec_wren, b_finish, b_fail}, 4'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1-byte build: identity S, enc 0x22 xor keystream 0x02 -> space
    prepare(1'b0, 24'd0, -1, 8'h00);
    b_fin = -1; b_dwr = 0; b_dec_last = 8'h00; b_fail_at = 1'bx;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    cyc = 1;
    while (cyc < 60 && b_fin < 0) begin
      if (b_dec_wren) begin b_dwr++; b_dec_last = b_dec_data; end
      if (b_finish) begin b_fin = cyc; b_fail_at = b_fail; end
      @(posedge clk); #1;
      cyc++;
    end
    check("len1_finish_cycle", b_fin, 13);
    check("len1_dec0", b_dec_last, 8'h20);
    check("len1_dec_writes", b_dwr, 1);
    check("len1_fail", {31'd0, b_fail_at}, 32'd0);

    // identity S, known keystream 02 05 07
    prepare(1'b0, 24'd0, -1, 8'h00);
    p[0] = 8'h61; p[1] = 8'h20; p[2] = 8'h61;
    apply_enc();
    run_main(-1);
    verify_run("ident", 385, 1'b0);
    check("ident_dec0", dec_mem[0], 8'h61);
    check("ident_dec1", dec_mem[1], 8'h20);
    check("ident_dec2", dec_mem[2], 8'h61);
    check("ident_s2_after3", snap2, 8'd3);
    check("ident_s3_after3", snap3, 8'd5);
    check("ident_s5_after3", snap5, 8'd2);

    // identity S, enc[0]=0 -> 0x02 written, abort after first byte
    prepare(1'b0, 24'd0, 0, 8'h02);
    enc_mem[0] = 8'h00;
    run_main(-1);
    verify_run("ident_abort", 13, 1'b1);
    check("ident_abort_dec0", dec_mem[0], 8'h02);

    // vector table: shuffled S with assorted keys and abort positions
    for (int v = 0; v < 6; v++) begin
      prepare(vecs[v].use_key, vecs[v].key, vecs[v].bad_pos, vecs[v].bad_val);
      run_main(-1);
      verify_run($sformatf("vec%0d", v), vecs[v].exp_fin, vecs[v].exp_fail);
    end

    // start pulsed during byte 5 is ignored
    prepare(1'b1, 24'h5EED01, -1, 8'h00);
    run_main(12 * 5 + 3);
    verify_run("restart_ignored", 385, 1'b0);

    // reset during WRITE_J of byte 3, then a clean rerun
    prepare(1'b1, 24'h0BADF0, -1, 8'h00);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 1;
    while (cyc < 42) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("writej_byte3_wren", {31'd0, o_s_wren}, 32'd1);
    check("writej_byte3_addr_vs_prev", {31'd0, o_dec_wren}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrun_reset_outs_lo", outs_lo(), 24'd0);
    check("midrun_reset_outs_hi", outs_hi(), 14'd0);
    @(posedge clk); #1;
    check("midrun_reset_hold_hi", outs_hi(), 14'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    prepare(1'b1, 24'h0BADF0, -1, 8'h00);
    run_main(-1);
    verify_run("after_reset", 385, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rc4_decryptor.md
# rc4_decryptor

RC4 keystream generator and message decryptor (PRGA stage) for the key-cracking datapath. It runs after the key-schedule shuffler has left the 256-byte S array permuted in the shared S RAM. It walks S to produce keystream bytes and XORs them with the encrypted-message ROM. Plaintext goes to the decrypted-message RAM, and any byte outside the allowed character set is flagged so the cracker can reject the candidate key early.

## Interface
- MSG_LEN, 32: message length in bytes; 1..256
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE
- s_q  in  8  S RAM read data
- s_address  out  8  S RAM address
- s_data  out  8  S RAM write data
- s_wren  out  1  S RAM write enable
- enc_q  in  8  encrypted ROM data
- enc_address  out  $clog2(MSG_LEN)  encrypted ROM address
- dec_address  out  $clog2(MSG_LEN)  decrypted RAM address
- dec_data  out  8  decrypted RAM write data
- dec_wren  out  1  decrypted RAM write enable
- finish  out  1  one-cycle done pulse
- fail  out  1  invalid plaintext seen; held until next accepted start

## Operation
- All memories are single-port with a registered address; read data is valid the cycle after the address is presented. Every read therefore has one WAIT state.
- Registers: i, j (8 b), k (message index), si, sj, f (8 b). All outputs are registered.
- On accepted start: i=1, j=0, k=0, fail=0.
- Per byte, the state sequence is:
  - READ_I: s_address=i
  - WAIT_I
  - LATCH_I: si=s_q; j=j+s_q; s_address=j+s_q
  - WAIT_J
  - LATCH_J: sj=s_q
  - WRITE_J: s_address=j, s_data=si, s_wren=1
  - WRITE_I: s_address=i, s_data=sj, s_wren=1
  - READ_F: s_address=si+sj; enc_address=k
  - WAIT_F
  - LATCH_F: f=s_q
  - WRITE_D: dec_address=k, dec_data=f^enc_q, dec_wren=1
  - NEXT
- All S arithmetic is mod 256 with the carry discarded.
- Valid plaintext byte: 0x61..0x7A or 0x20.
- A byte that fails the check is still written. fail is set in WRITE_D, and NEXT then goes to DONE.
- NEXT: if fail or k==MSG_LEN-1, go to DONE. Otherwise k++, i++, go to READ_I.
- DONE: finish=1 for one cycle, then IDLE. fail is left unchanged.
- i==j: both writes hit the same location with the same value. No special case.
- start while not in IDLE is ignored. start held high re-launches from IDLE after DONE.

## Timing
- Reset values: all outputs 0; state=IDLE; i, j, k, si, sj, f = 0.
- Reset mid-run returns to IDLE at once. RAM contents are left as-is; no completion pulse.
- Per-byte cost is 12 cycles.
- start is sampled high in IDLE at edge 0.
- READ_I of byte 0 is the cycle after edge 0.
- finish is high in cycle 12·MSG_LEN+1 after a clean run.
- On abort at byte n, finish is high in cycle 12·(n+1)+1.
- s_wren is high exactly in WRITE_J and WRITE_I. dec_wren is high exactly in WRITE_D.
- Each write enable is high for exactly one cycle per byte.
- Outside WRITE_* states, s_data and dec_data hold their last value.
- Addresses change only on the state transitions listed above.

## Structure
- Package rc4_pkg:
  - state enum
  - CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SPACE=8'h20
  - default MSG_LEN
- Sub-module rc4_char_check: combinational 8-bit in, valid out. It is shared with the cracker's key-selection logic.
- Single always_ff FSM with registered outputs.

## Test plan
- Identity S (s[n]=n); enc = {0x63,0x25,0x66,...} -> keystream 0x02,0x05,0x07; dec[0..2]=0x61,0x20,0x61. After the first three bytes, s[2]=3, s[3]=5, s[5]=2.
- Identity S; enc[0]=0x00 -> dec[0]=0x02 written; fail=1; finish in cycle 13; dec[1] not written.
- S from shuffler with a known key; enc = reference-model ciphertext of a 32-char lowercase string -> all 32 dec bytes match; fail=0; finish in cycle 385.
- start pulsed again during byte 5 -> ignored; k continues; single finish.
- reset_n low during WRITE_J of byte 3 -> all outputs 0 next cycle; IDLE. A new start runs from i=1, j=0 (bench reloads S).
- MSG_LEN=1 build; identity S; enc[0]=0x22 -> dec[0]=0x20; finish in cycle 13; fail=0.
